// File: rtl/updown_mod.sv
// Parametrised synchronous up/down counter with load, per-cycle wrap/saturate and ovf/unf pulses.
// Define UPDN_STEP_EN to add a variable step input; otherwise the step is fixed at 1.
module updown_mod #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDN_STEP_EN
    input  logic [WIDTH-1:0] step,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);

    // Count arithmetic runs one bit wider than q so sums and wrap offsets never truncate.
    localparam logic [WIDTH:0]   MAX_EXT  = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0]   MOD      = {1'b0, MAX_VAL} + {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RST_SAFE = (RST_VAL > MAX_VAL) ? MAX_VAL : RST_VAL;

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] step_eff;
    logic [WIDTH-1:0] load_clamp;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH:0]   up_sum;

`ifdef UPDN_STEP_EN
    assign step_eff = (step > MAX_VAL) ? MAX_VAL : step;
`else
    assign step_eff = WIDTH'(1);
`endif

    assign load_clamp = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    assign q_ext      = {1'b0, q_q};
    assign s_ext      = {1'b0, step_eff};
    assign up_sum     = q_ext + s_ext;

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (load) begin
            q_d = load_clamp;
        end else if (en) begin
            if (up) begin
                if (up_sum > MAX_EXT) begin
                    ovf_d = 1'b1;
                    q_d   = sat ? MAX_VAL : WIDTH'(up_sum - MOD);
                end else begin
                    q_d = WIDTH'(up_sum);
                end
            end else begin
                if (q_ext < s_ext) begin
                    unf_d = 1'b1;
                    q_d   = sat ? '0 : WIDTH'(q_ext + MOD - s_ext);
                end else begin
                    q_d = q_q - step_eff;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= RST_SAFE;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign q      = q_q;
    assign qn     = ~q_q;
    assign at_max = (q_q == MAX_VAL);
    assign at_min = (q_q == '0);
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: tb/tb_updown_mod.sv
// Self-checking bench for updown_mod: directed scenarios plus randomized traffic against an integer model.
// Two instances: WIDTH=4/MAX_VAL=9/RST_VAL=3 and WIDTH=8/MAX_VAL=255/RST_VAL=5.
module tb_updown_mod;

    localparam int M4 = 9;
    localparam int R4 = 3;
    localparam int M8 = 255;
    localparam int R8 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, en4, up4, sat4, load4;
    logic [3:0] lv4, q4, qn4;
    logic       atmax4, atmin4, ovf4, unf4;
    logic       rst8, en8, up8, sat8, load8;
    logic [7:0] lv8, q8, qn8;
    logic       atmax8, atmin8, ovf8, unf8;
`ifdef UPDN_STEP_EN
    logic [3:0] step4;
    logic [7:0] step8;
`endif

    int checks = 0;
    int errors = 0;

    int mq4, mq8;
    bit mo4, mu4, mo8, mu8;

    updown_mod #(.WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd3)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .up(up4), .sat(sat4), .load(load4), .load_val(lv4),
`ifdef UPDN_STEP_EN
        .step(step4),
`endif
        .q(q4), .qn(qn4), .at_max(atmax4), .at_min(atmin4), .ovf(ovf4), .unf(unf4)
    );

    updown_mod #(.WIDTH(8), .MAX_VAL(8'd255), .RST_VAL(8'd5)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up(up8), .sat(sat8), .load(load8), .load_val(lv8),
`ifdef UPDN_STEP_EN
        .step(step8),
`endif
        .q(q8), .qn(qn8), .at_max(atmax8), .at_min(atmin8), .ovf(ovf8), .unf(unf8)
    );

    // Reference: count range 0..maxv treated as integers modulo maxv+1, clamped in saturate mode.
    function automatic void model_next(input int maxv, input int rstv, input bit r, input bit l,
                                       input bit e, input bit u, input bit sa, input int lv,
                                       input int step_raw, inout int q, output bit o, output bit n);
        int s;
        int modv;
        modv = maxv + 1;
        s    = (step_raw < maxv) ? step_raw : maxv;
        o    = 1'b0;
        n    = 1'b0;
        if (r) begin
            q = rstv;
        end else if (l) begin
            q = (lv < maxv) ? lv : maxv;
        end else if (e) begin
            if (u) begin
                o = ((q + s) > maxv);
                q = (o && sa) ? maxv : (q + s) % modv;
            end else begin
                n = (q < s);
                q = (n && sa) ? 0 : (q - s + modv) % modv;
            end
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int exp_q[9];
        exp_q = '{4, 5, 6, 7, 8, 9, 0, 1, 2};
        rst4 = 1'b1; load4 = 1'b1; lv4 = 4'd7; en4 = 1'b1; up4 = 1'b1; sat4 = 1'b0;
        rst8 = 1'b1; load8 = 1'b1; lv8 = 8'hAA; en8 = 1'b1; up8 = 1'b1; sat8 = 1'b0;
        tick;
        checks++;
        if (q4 !== 4'd3 || qn4 !== 4'hC || ovf4 !== 1'b0 || unf4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset4 q=%0d qn=%h ovf=%b unf=%b expected q=3 qn=c ovf=0 unf=0", q4, qn4, ovf4, unf4);
        end
        checks++;
        if (q8 !== 8'd5 || ovf8 !== 1'b0 || unf8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset8 q=%0d ovf=%b unf=%b expected q=5 ovf=0 unf=0", q8, ovf8, unf8);
        end
        rst4 = 1'b0; load4 = 1'b0;
        rst8 = 1'b0; load8 = 1'b0; en8 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick;
            checks++;
            if (q4 !== 4'(exp_q[i]) || ovf4 !== (i == 6)) begin
                errors++;
                $display("[TB] FAIL reset_count[%0d] q=%0d ovf=%b expected q=%0d ovf=%b", i, q4, ovf4, exp_q[i], (i == 6));
            end
        end
        en4 = 1'b0;
    endtask

    task automatic test_wrap_down;
        load4 = 1'b1; lv4 = 4'd0;
        tick;
        checks++;
        if (q4 !== 4'd0 || atmin4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_down_load q=%0d at_min=%b expected q=0 at_min=1", q4, atmin4);
        end
        load4 = 1'b0; en4 = 1'b1; up4 = 1'b0; sat4 = 1'b0;
        tick;
        checks++;
        if (q4 !== 4'd9 || unf4 !== 1'b1 || atmax4 !== 1'b1 || ovf4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_down q=%0d unf=%b at_max=%b expected q=9 unf=1 at_max=1", q4, unf4, atmax4);
        end
        tick;
        checks++;
        if (q4 !== 4'd8 || unf4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_down_next q=%0d unf=%b expected q=8 unf=0", q4, unf4);
        end
        en4 = 1'b0;
    endtask

    task automatic test_saturate;
        int eq;
        load4 = 1'b1; lv4 = 4'd8;
        tick;
        load4 = 1'b0; en4 = 1'b1; up4 = 1'b1; sat4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (q4 !== 4'd9 || ovf4 !== (i != 0) || atmax4 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sat_up[%0d] q=%0d ovf=%b at_max=%b expected q=9 ovf=%b at_max=1", i, q4, ovf4, atmax4, (i != 0));
            end
        end
        up4 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            eq = (9 - i > 0) ? 9 - i : 0;
            checks++;
            if (q4 !== 4'(eq) || unf4 !== (i == 10) || ovf4 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sat_down[%0d] q=%0d unf=%b expected q=%0d unf=%b", i, q4, unf4, eq, (i == 10));
            end
        end
        en4 = 1'b0; sat4 = 1'b0;
    endtask

    task automatic test_load_clamp;
        load4 = 1'b1; lv4 = 4'd14; en4 = 1'b1; up4 = 1'b1; sat4 = 1'b0;
        tick;
        checks++;
        if (q4 !== 4'd9 || ovf4 !== 1'b0 || atmax4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_clamp q=%0d ovf=%b at_max=%b expected q=9 ovf=0 at_max=1", q4, ovf4, atmax4);
        end
        lv4 = 4'd6; up4 = 1'b0;
        tick;
        checks++;
        if (q4 !== 4'd6 || unf4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_plain q=%0d unf=%b expected q=6 unf=0", q4, unf4);
        end
        rst4 = 1'b1; lv4 = 4'd14;
        tick;
        checks++;
        if (q4 !== 4'd3 || ovf4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_vs_reset q=%0d ovf=%b expected q=3 ovf=0", q4, ovf4);
        end
        rst4 = 1'b0; load4 = 1'b0; en4 = 1'b0;
    endtask

`ifdef UPDN_STEP_EN
    task automatic test_step;
        load4 = 1'b1; lv4 = 4'd7;
        tick;
        load4 = 1'b0; en4 = 1'b1; up4 = 1'b1; sat4 = 1'b0; step4 = 4'd5;
        tick;
        checks++;
        if (q4 !== 4'd2 || ovf4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL step5 q=%0d ovf=%b expected q=2 ovf=1", q4, ovf4);
        end
        step4 = 4'd15;
        tick;
        checks++;
        if (q4 !== 4'd1 || ovf4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL step15 q=%0d ovf=%b expected q=1 ovf=1", q4, ovf4);
        end
        step4 = 4'd0;
        tick;
        checks++;
        if (q4 !== 4'd1 || ovf4 !== 1'b0 || unf4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL step0_up q=%0d ovf=%b unf=%b expected q=1 ovf=0 unf=0", q4, ovf4, unf4);
        end
        up4 = 1'b0;
        tick;
        checks++;
        if (q4 !== 4'd1 || ovf4 !== 1'b0 || unf4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL step0_down q=%0d ovf=%b unf=%b expected q=1 ovf=0 unf=0", q4, ovf4, unf4);
        end
        en4 = 1'b0; step4 = 4'd1;
    endtask
`endif

    task automatic test_mid_reset;
        load8 = 1'b1; lv8 = 8'h70;
        tick;
        load8 = 1'b0; en8 = 1'b1; up8 = 1'b1; sat8 = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick;
            checks++;
            if (q8 !== 8'(8'h70 + i) || ovf8 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mid_count[%0d] q=%h ovf=%b expected q=%h ovf=0", i, q8, ovf8, 8'h70 + i);
            end
        end
        rst8 = 1'b1;
        tick;
        checks++;
        if (q8 !== 8'd5 || ovf8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset q=%0d ovf=%b expected q=5 ovf=0", q8, ovf8);
        end
        rst8 = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick;
            checks++;
            if (q8 !== 8'(5 + i)) begin
                errors++;
                $display("[TB] FAIL mid_resume[%0d] q=%0d expected q=%0d", i, q8, 5 + i);
            end
        end
        load8 = 1'b1; lv8 = 8'hFE;
        tick;
        load8 = 1'b0;
        tick;
        checks++;
        if (q8 !== 8'hFF || ovf8 !== 1'b0 || atmax8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL top8 q=%h ovf=%b at_max=%b expected q=ff ovf=0 at_max=1", q8, ovf8, atmax8);
        end
        tick;
        checks++;
        if (q8 !== 8'h00 || ovf8 !== 1'b1 || atmin8 !== 1'b1 || qn8 !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL wrap8 q=%h ovf=%b at_min=%b qn=%h expected q=00 ovf=1 at_min=1 qn=ff", q8, ovf8, atmin8, qn8);
        end
        en8 = 1'b0;
    endtask

    task automatic test_random;
        bit r, l, e, u, sa;
        int lv, sv;
        for (int i = 0; i < 400; i++) begin
            r  = (i == 0) || ($urandom_range(31) == 0);
            l  = ($urandom_range(7) == 0);
            e  = ($urandom_range(3) != 0);
            u  = ($urandom_range(1) == 1);
            sa = ($urandom_range(1) == 1);
            lv = $urandom_range(15);
            rst4 = r; load4 = l; en4 = e; up4 = u; sat4 = sa; lv4 = 4'(lv);
`ifdef UPDN_STEP_EN
            sv = $urandom_range(15);
            step4 = 4'(sv);
`else
            sv = 1;
`endif
            model_next(M4, R4, r, l, e, u, sa, lv, sv, mq4, mo4, mu4);

            r  = (i == 0) || ($urandom_range(31) == 0);
            l  = ($urandom_range(15) == 0);
            e  = ($urandom_range(3) != 0);
            u  = ($urandom_range(1) == 1);
            sa = ($urandom_range(1) == 1);
            lv = ($urandom_range(3) == 0) ? 255 - $urandom_range(3) : $urandom_range(255);
            rst8 = r; load8 = l; en8 = e; up8 = u; sat8 = sa; lv8 = 8'(lv);
`ifdef UPDN_STEP_EN
            sv = ($urandom_range(1) == 1) ? $urandom_range(3) : $urandom_range(255);
            step8 = 8'(sv);
`else
            sv = 1;
`endif
            model_next(M8, R8, r, l, e, u, sa, lv, sv, mq8, mo8, mu8);

            tick;
            checks++;
            if ({q4, qn4, atmax4, atmin4, ovf4, unf4} !==
                {4'(mq4), 4'(15 - mq4), (mq4 == M4), (mq4 == 0), mo4, mu4}) begin
                errors++;
                $display("[TB] FAIL rand4[%0d] q=%0d qn=%h max=%b min=%b ovf=%b unf=%b expected q=%0d ovf=%b unf=%b",
                         i, q4, qn4, atmax4, atmin4, ovf4, unf4, mq4, mo4, mu4);
            end
            checks++;
            if ({q8, qn8, atmax8, atmin8, ovf8, unf8} !==
                {8'(mq8), 8'(255 - mq8), (mq8 == M8), (mq8 == 0), mo8, mu8}) begin
                errors++;
                $display("[TB] FAIL rand8[%0d] q=%0d qn=%h max=%b min=%b ovf=%b unf=%b expected q=%0d ovf=%b unf=%b",
                         i, q8, qn8, atmax8, atmin8, ovf8, unf8, mq8, mo8, mu8);
            end
        end
    endtask

    initial begin
        rst4 = 1'b0; en4 = 1'b0; up4 = 1'b0; sat4 = 1'b0; load4 = 1'b0; lv4 = '0;
        rst8 = 1'b0; en8 = 1'b0; up8 = 1'b0; sat8 = 1'b0; load8 = 1'b0; lv8 = '0;
`ifdef UPDN_STEP_EN
        step4 = 4'd1; step8 = 8'd1;
`endif
        mq4 = R4; mq8 = R8;
        test_reset;
        test_wrap_down;
        test_saturate;
        test_load_clamp;
`ifdef UPDN_STEP_EN
        test_step;
`endif
        test_mid_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
